// File: rtl/fetch_request_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_request_unit_if
//   Bundles the instruction-memory request/response channel and the
//   decode-side valid/ready channel of the fetch request unit.
//
//   Signals:
//     req_valid  : imem request valid                   (fetch -> imem)
//     req_addr   : block-aligned request address        (fetch -> imem)
//     req_ready  : imem accepts the request             (imem  -> fetch)
//     resp_valid : in-order response valid, no backpr.  (imem  -> fetch)
//     resp_data  : response block, instr 0 in low bits  (imem  -> fetch)
//     valid      : fetch block available                (fetch -> decode)
//     pc         : PC that produced the block           (fetch -> decode)
//     data       : block data                           (fetch -> decode)
//     mask       : lanes at or after pc in the block    (fetch -> decode)
//     ready      : decode consumes the head block       (decode -> fetch)
//
//   Modports: master = fetch unit side, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface fetch_request_unit_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned PC_WIDTH    = 32
);
  logic                      req_valid;
  logic [PC_WIDTH-1:0]       req_addr;
  logic                      req_ready;
  logic                      resp_valid;
  logic [FETCH_WIDTH*32-1:0] resp_data;
  logic                      valid;
  logic [PC_WIDTH-1:0]       pc;
  logic [FETCH_WIDTH*32-1:0] data;
  logic [FETCH_WIDTH-1:0]    mask;
  logic                      ready;

  modport master (
    output req_valid, req_addr, valid, pc, data, mask,
    input  req_ready, resp_valid, resp_data, ready
  );

  modport slave (
    input  req_valid, req_addr, valid, pc, data, mask,
    output req_ready, resp_valid, resp_data, ready
  );
endinterface

// File: rtl/fetch_request_unit.sv
// ---------------------------------------------------------------------------
// fetch_request_unit
//   Consumer end of the program-counter -> fetch path. Each cycle it may
//   issue one block-aligned instruction-memory request for the current PC,
//   remembers the PC in a pending FIFO, pairs in-order memory responses with
//   those PCs and buffers the resulting blocks in a fetch queue for decode.
//   A credit scheme (in-flight + to-be-dropped + buffered <= FQ_DEPTH)
//   guarantees every response finds a queue slot. On a redirect the queue
//   and pending FIFO are cleared and responses still in flight are counted
//   so they can be discarded when they arrive.
//
//   Ports:
//     i_clk    : clock
//     i_rst_n  : synchronous active-low reset
//     i_pc     : current fetch PC from the PC register
//     o_stall  : hold the PC (high when no request is accepted this cycle)
//     i_flush  : redirect from writeback
//     bus      : imem request/response + decode handshake (master modport)
// ---------------------------------------------------------------------------
module fetch_request_unit #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned FQ_DEPTH    = 4,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PC_WIDTH-1:0]  i_pc,
  output logic                 o_stall,
  input  logic                 i_flush,
  fetch_request_unit_if.master bus
);

  localparam int unsigned DATA_W = FETCH_WIDTH * 32;
  localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  // Headroom so the three-way credit sum can never wrap.
  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam logic [PC_WIDTH-1:0] BLK_OFFS = PC_WIDTH'(FETCH_WIDTH * 4 - 1);

  // Lane mask: lane i is live when it sits at or after the fetched word.
  function automatic logic [FETCH_WIDTH-1:0] lane_mask(input logic [PC_WIDTH-1:0] pc);
    logic [PC_WIDTH-1:0] word;
    word      = (pc >> 2) & PC_WIDTH'(FETCH_WIDTH - 1);
    lane_mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask[i] = (PC_WIDTH'(i) >= word);
    end
  endfunction

  // Pending-PC FIFO (PCs of accepted, not yet answered requests).
  logic [PC_WIDTH-1:0]    pend_pc_q [FQ_DEPTH];
  logic [PTR_W-1:0]       pend_wr_q, pend_wr_d;
  logic [PTR_W-1:0]       pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]       inflight_q, inflight_d;

  // Responses still owed by memory for requests cancelled by a redirect.
  logic [CNT_W-1:0]       drop_q, drop_d;

  // Fetch queue toward decode.
  logic [PC_WIDTH-1:0]    fq_pc_q   [FQ_DEPTH];
  logic [DATA_W-1:0]      fq_data_q [FQ_DEPTH];
  logic [FETCH_WIDTH-1:0] fq_mask_q [FQ_DEPTH];
  logic [PTR_W-1:0]       fq_wr_q, fq_wr_d;
  logic [PTR_W-1:0]       fq_rd_q, fq_rd_d;
  logic [CNT_W-1:0]       q_count_q, q_count_d;

  logic [SUM_W-1:0]       total_s;
  logic                   req_valid_s;
  logic                   accept_s;
  logic                   resp_drop_s;
  logic                   resp_pair_s;
  logic                   resp_err_s;
  logic                   fq_push_s;
  logic                   fq_pop_s;
  logic [PC_WIDTH-1:0]    resp_pc_s;

  assign total_s     = SUM_W'(inflight_q) + SUM_W'(drop_q) + SUM_W'(q_count_q);
  assign req_valid_s = i_rst_n & ~i_flush & (total_s < SUM_W'(FQ_DEPTH));
  assign accept_s    = req_valid_s & bus.req_ready;

  // A response first pays off cancelled requests, then pairs with the
  // oldest pending PC; with neither outstanding it is a protocol error.
  assign resp_drop_s = bus.resp_valid & (drop_q != '0);
  assign resp_pair_s = bus.resp_valid & (drop_q == '0) & (inflight_q != '0);
  assign resp_err_s  = bus.resp_valid & (drop_q == '0) & (inflight_q == '0);
  assign resp_pc_s   = pend_pc_q[pend_rd_q];

  // A redirect wins over every push and pop into the fetch queue.
  assign fq_push_s   = resp_pair_s & ~i_flush;
  assign fq_pop_s    = (q_count_q != '0) & bus.ready & ~i_flush;

  assign bus.req_valid = req_valid_s;
  assign bus.req_addr  = i_pc & ~BLK_OFFS;
  assign o_stall       = ~accept_s;

  assign bus.valid = (q_count_q != '0);
  assign bus.pc    = fq_pc_q[fq_rd_q];
  assign bus.data  = fq_data_q[fq_rd_q];
  assign bus.mask  = fq_mask_q[fq_rd_q];

  // Next-state for pointers and counters; redirect clears everything but
  // converts in-flight requests into responses to be dropped.
  always_comb begin
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    q_count_d  = q_count_q;
    if (i_flush) begin
      pend_wr_d  = '0;
      pend_rd_d  = '0;
      inflight_d = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      q_count_d  = '0;
      // Pre-flush counts; only a response that consumed a credit is removed.
      drop_d     = drop_q + inflight_q - CNT_W'(resp_drop_s | resp_pair_s);
    end else begin
      pend_wr_d  = accept_s    ? pend_wr_q + PTR_W'(1) : pend_wr_q;
      pend_rd_d  = resp_pair_s ? pend_rd_q + PTR_W'(1) : pend_rd_q;
      inflight_d = inflight_q + CNT_W'(accept_s) - CNT_W'(resp_pair_s);
      drop_d     = drop_q - CNT_W'(resp_drop_s);
      fq_wr_d    = fq_push_s ? fq_wr_q + PTR_W'(1) : fq_wr_q;
      fq_rd_d    = fq_pop_s  ? fq_rd_q + PTR_W'(1) : fq_rd_q;
      q_count_d  = q_count_q + CNT_W'(fq_push_s) - CNT_W'(fq_pop_s);
    end
  end

  // Pointer and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      q_count_q  <= '0;
    end else begin
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      q_count_q  <= q_count_d;
    end
  end

  // Pending-PC storage; validity is tracked by the counters, so no reset.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      pend_pc_q[pend_wr_q] <= i_pc;
    end
  end

  // Fetch-queue storage, written when a response pairs with its PC.
  always_ff @(posedge i_clk) begin
    if (fq_push_s) begin
      fq_pc_q[fq_wr_q]   <= resp_pc_s;
      fq_data_q[fq_wr_q] <= bus.resp_data;
      fq_mask_q[fq_wr_q] <= lane_mask(resp_pc_s);
    end
  end

`ifndef SYNTHESIS
  // Flag a memory response that has no outstanding request behind it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && resp_err_s) begin
      $error("fetch_request_unit: response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
module tb_fetch_request_unit;
  localparam int unsigned FW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PCW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic [31:0] pc;
  logic        stall;

  fetch_request_unit_if #(.FETCH_WIDTH(FW), .PC_WIDTH(PCW)) bus ();

  fetch_request_unit #(.FETCH_WIDTH(FW), .FQ_DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pc    (pc),
    .o_stall (stall),
    .i_flush (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic [1:0]  mask;
  } blk_t;

  // Behavioural model: queues of PCs and blocks, plus a drop count.
  blk_t        fq[$];
  logic [31:0] pend[$];
  int          drop;
  // Memory model: accepted block addresses with their issue cycle.
  logic [31:0] mem_a[$];
  int          mem_t[$];
  int          cyc;
  logic [31:0] dut_pop[$];

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [63:0] blk_data(input logic [31:0] addr);
    return {addr ^ 32'h8000_0013, addr ^ 32'h8010_0093};
  endfunction

  // Lanes at or after the fetched word within an 8-byte block.
  function automatic logic [1:0] exp_mask(input logic [31:0] p);
    int w;
    logic [1:0] m;
    w = int'((p % 32'd8) / 32'd4);
    for (int i = 0; i < 2; i++) m[i] = (i >= w);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against model, advance model.
  task automatic cycle(input logic r, input logic f, input logic rr, input logic want,
                       input logic rdy, output logic acc_dut);
    logic        rv;
    logic [63:0] rd;
    int          total;
    logic        exp_rv;
    logic        acc;
    logic        consumes;
    logic        pop_ok;
    blk_t        b;
    rv = r && want && (mem_a.size() > 0) && (mem_t.size() > 0) && (mem_t[0] < cyc);
    rd = rv ? blk_data(mem_a[0]) : 64'h0;
    rst_n          = r;
    flush          = f;
    bus.req_ready  = rr;
    bus.resp_valid = rv;
    bus.resp_data  = rd;
    bus.ready      = rdy;
    #2;
    total  = pend.size() + drop + fq.size();
    exp_rv = r && !f && (total < DEPTH);
    acc    = exp_rv && rr;
    acc_dut = bus.req_valid && rr;
    chk("req_valid", bus.req_valid, exp_rv);
    chk("stall", stall, !acc);
    chk("req_addr", bus.req_addr, pc & ~32'h7);
    chk("valid", bus.valid, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("o_pc", bus.pc, fq[0].pc);
      chk("o_data", bus.data, fq[0].data);
      chk("o_mask", bus.mask, fq[0].mask);
    end
    if (bus.valid && rdy && r && !f) dut_pop.push_back(bus.pc);
    if (!r) begin
      pend.delete(); fq.delete(); drop = 0; mem_a.delete(); mem_t.delete();
    end else begin
      consumes = rv && (drop > 0 || pend.size() > 0);
      if (rv) begin
        void'(mem_a.pop_front());
        void'(mem_t.pop_front());
      end
      if (f) begin
        drop = drop + pend.size() - (consumes ? 1 : 0);
        pend.delete();
        fq.delete();
      end else begin
        pop_ok = (fq.size() != 0) && rdy;
        if (pop_ok) void'(fq.pop_front());
        if (rv) begin
          if (drop > 0) drop--;
          else if (pend.size() > 0) begin
            b.pc   = pend.pop_front();
            b.data = rd;
            b.mask = exp_mask(b.pc);
            fq.push_back(b);
          end
        end
        if (acc) pend.push_back(pc);
      end
      if (acc) begin
        mem_a.push_back(pc & ~32'h7);
        mem_t.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic a;
    int   n_acc;
    logic r, f, rr, want, rdy;
    rst_n = 1'b0; flush = 1'b0; pc = 32'h0;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = 64'h0; bus.ready = 1'b0;
    drop = 0; cyc = 0;
    @(posedge clk);
    #1;

    // Reset state
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_stall", stall, 1'b1);

    // Basic fetch
    pc = 32'h8000_0004; rst_n = 1'b1; flush = 1'b0; bus.req_ready = 1'b1;
    #1;
    chk("basic_addr", bus.req_addr, 32'h8000_0000);
    chk("basic_stall", stall, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    pc = 32'h8000_0008;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
    chk("basic_valid", bus.valid, 1'b1);
    chk("basic_pc", bus.pc, 32'h8000_0004);
    chk("basic_mask", bus.mask, 2'b10);
    chk("basic_data", bus.data, 64'h00000013_00100093);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a);

    // Credit stall: decode never ready, responses one cycle after requests
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    pc = 32'h0000_1000; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
      if (a) begin n_acc++; pc = pc + 32'h8; end
    end
    chk("credit_accepts", n_acc, 4);
    bus.req_ready = 1'b1; bus.ready = 1'b0; bus.resp_valid = 1'b0;
    #1;
    chk("credit_req_valid", bus.req_valid, 1'b0);
    chk("credit_stall", stall, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a);
    if (a) n_acc++;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
      if (a) begin n_acc++; pc = pc + 32'h8; end
    end
    chk("credit_after_pop", n_acc, 5);

    // Flush with two requests in flight, no response in the flush cycle
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    pc = 32'h8000_0100; cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    pc = 32'h8000_0108; cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a);
    pc = 32'h8000_1000; cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    pc = 32'h8000_1008; cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
    chk("flush_drop2_valid", bus.valid, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
    chk("flush_third_valid", bus.valid, 1'b1);
    chk("flush_third_pc", bus.pc, 32'h8000_1000);

    // Flush coincident with a response
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    pc = 32'h0000_0200; cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    pc = 32'h0000_0208; cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, a);
    chk("flushc_empty", bus.valid, 1'b0);
    pc = 32'h0000_0300; cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    chk("flushc_dropped", bus.valid, 1'b0);
    pc = 32'h0000_0308; cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
    chk("flushc_pc", bus.pc, 32'h0000_0300);

    // Simultaneous push/pop at two buffered blocks
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    dut_pop.delete();
    pc = 32'h0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, (i >= 3), a);
      if (a) pc = pc + 32'h8;
    end
    chk("pp_count", dut_pop.size() >= 3, 1'b1);
    if (dut_pop.size() >= 3) begin
      chk("pp_order0", dut_pop[0], 32'h0);
      chk("pp_order1", dut_pop[1], 32'h8);
      chk("pp_order2", dut_pop[2], 32'h10);
    end

    // Reset mid-stream (queue 3, one in flight)
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    if (a) pc = pc + 32'h8;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    chk("mrst_valid", bus.valid, 1'b0);
    chk("mrst_req_valid", bus.req_valid, 1'b0);
    chk("mrst_stall", stall, 1'b1);
    rst_n = 1'b1; flush = 1'b0; bus.req_ready = 1'b1;
    #1;
    chk("mrst_credits_free", bus.req_valid, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 199) != 0);
      f    = ($urandom_range(0, 24) == 0);
      rr   = ($urandom_range(0, 9) < 7);
      want = ($urandom_range(0, 9) < 6);
      rdy  = ($urandom_range(0, 9) < 5);
      cycle(r, f, rr, want, rdy, a);
      if (f || !r) pc = $urandom & 32'hFFFF_FFFC;
      else if (a) pc = (pc & ~32'h7) + 32'h8;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
